usb_rx_ctrl: RTL
================

# usb_rx_ctrl

Receive-path sequencer for the USB full-speed device core. It sits between the bit-clock-recovery / NRZI decoder pair and the packet layer. It hunts for SYNC in the decoded bitstream and removes stuffed bits. It assembles LSB-first bytes, detects EOP from raw line state, and flags receive errors, presenting one byte per pulse to the packet decoder with packet framing (active / end / error).

## Interface

Parameters:
- SYNC_MIN_ZEROS, 5: consecutive decoded 0s required before the terminating 1 of SYNC (tolerates dropped leading SYNC bits).
- EOP_SE0_MIN, 2: minimum SE0 strobes before J to accept EOP.
- CNT_W, 11: byte counter width (1026 max FS packet fits).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rx_en  in  1  receiver enable; low forces IDLE
- phase_lock  in  1  BCR lock indicator
- line_strobe  in  1  BCR bit strobe, one cycle per bit time
- line_state  in  2  raw line state (01=J, 10=K, 00=SE0, 11=SE1), qualified by line_strobe
- dec_bit  in  1  NRZI-decoded bit
- dec_valid  in  1  dec_bit qualifier (one cycle after the corresponding J/K strobe)
- rx_data  out  8  assembled byte, LSB = first received bit
- rx_valid  out  1  one-cycle pulse, rx_data valid
- rx_active  out  1  high from SYNC found until EOP/abort
- rx_eop  out  1  one-cycle pulse, clean packet end
- rx_error  out  1  one-cycle pulse, packet aborted
- rx_err_code  out  2  held from rx_error until next SYNC: 01 stuff, 10 byte-align, 11 SE1/lock loss
- rx_byte_cnt  out  CNT_W  bytes delivered in current packet, saturating

## Operation

- States: IDLE, HUNT, DATA, EOP, WAIT_J.
- IDLE: entered on reset or rx_en=0. Moves to HUNT when rx_en=1 and phase_lock=1.
- HUNT: zero counter increments on dec_valid with bit 0. A decoded 1 with count ≥ SYNC_MIN_ZEROS enters DATA, asserts rx_active, clears byte/bit counters, ones counter and rx_err_code. A 1 with a lower count clears the zero counter.
- DATA, per dec_valid:
  - If ones_cnt==6 (stuff slot): bit 0 is discarded and clears ones_cnt. Bit 1 aborts with code 01.
  - Otherwise the bit is shifted into the byte register (shift right, new bit at [7]). ones_cnt increments on 1 and clears on 0; bit_cnt increments.
  - At bit_cnt==8: pulse rx_valid, update rx_data, increment rx_byte_cnt (saturate at all-ones), clear bit_cnt.
- A stuffed bit is never counted and never delivered. ones_cnt spans byte boundaries.
- SE0 on line_strobe in DATA enters EOP with se0_cnt=1.
- EOP: each further SE0 strobe increments se0_cnt (saturate at 3).
  - J strobe with se0_cnt ≥ EOP_SE0_MIN: if bit_cnt==0, pulse rx_eop; else abort with code 10. Then go to HUNT.
  - J with se0_cnt < EOP_SE0_MIN, or K: abort with code 10.
- Abort: pulse rx_error, latch code, drop rx_active, go to WAIT_J. WAIT_J returns to HUNT on the first J strobe (with phase_lock=1).
- SE1 strobe, or phase_lock falling, in DATA or EOP aborts with code 11.
- rx_en falling while rx_active: abort with code 11, then IDLE.
- Simultaneous events: abort outranks a same-cycle byte completion, so rx_valid is suppressed. A line SE0 strobe and a late dec_valid in the same cycle are both processed, bit first.

## Timing

- Reset values: rx_data=0, rx_valid=0, rx_active=0, rx_eop=0, rx_error=0, rx_err_code=0, rx_byte_cnt=0, state IDLE.
- All outputs are registered.
- rx_valid asserts in the cycle after the dec_valid carrying the byte's 8th data bit.
- rx_active rises the cycle after the SYNC-terminating dec_valid.
- rx_active falls in the same cycle rx_eop or rx_error pulses, which is the cycle after the terminating strobe.
- rx_eop and rx_error are mutually exclusive.
- rx_valid never asserts while rx_active=0.
- No backpressure. The consumer must accept a byte in the rx_valid cycle. The minimum byte spacing is 8 strobe periods.

## Structure

- Shared package usb_rx_pkg holds:
  - line-state constants (LS_J, LS_K, LS_SE0, LS_SE1);
  - state enum rx_state_t;
  - error-code constants ERR_NONE / ERR_STUFF / ERR_ALIGN / ERR_LINE;
  - STUFF_LIMIT=6.
- One natural sub-module: usb_bit_unstuff. It holds the ones counter and stuff-slot detection, and outputs keep / stuff_err per valid bit. The FSM, byte assembler and EOP logic remain in usb_rx_ctrl.

## Test plan

- SYNC 00000001, data 0xA5, SE0×2, J → rx_valid with rx_data=0xA5, rx_byte_cnt=1, rx_eop one cycle, no rx_error.
- SYNC with only 5 zeros + 1 → lock (default parameter). Same check with 4 zeros + 1 → remains in HUNT, no rx_active.
- Data 0xFF,0xFF with a stuffed 0 after each 6 ones → bytes 0xFF,0xFF delivered, stuffed bits absent. Replace the first stuffed 0 with 1 → rx_error, rx_err_code=01, no second rx_valid.
- 12 data bits then SE0×2, J → one rx_valid, then rx_error with code 10, no rx_eop.
- Mid-packet SE1 strobe; separately, phase_lock drop after 3 bytes → rx_error with code 11. Recovery: J then a new SYNC relocks and rx_err_code clears.
- rst asserted mid-byte (asynchronously, between clock edges) → all outputs 0 immediately. After release, the first valid SYNC+0x3C is received correctly.

Source files
------------

// File: rtl/usb_rx_pkg.sv
// usb_rx_pkg: line-state, error-code and FSM-state definitions shared by the USB receive path
package usb_rx_pkg;
    localparam logic [1:0] LS_SE0 = 2'b00;
    localparam logic [1:0] LS_J   = 2'b01;
    localparam logic [1:0] LS_K   = 2'b10;
    localparam logic [1:0] LS_SE1 = 2'b11;
    localparam logic [1:0] ERR_NONE  = 2'b00;
    localparam logic [1:0] ERR_STUFF = 2'b01;
    localparam logic [1:0] ERR_ALIGN = 2'b10;
    localparam logic [1:0] ERR_LINE  = 2'b11;
    localparam int STUFF_LIMIT = 6;
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HUNT,
        ST_DATA,
        ST_EOP,
        ST_WAIT_J
    } rx_state_t;
endpackage

// File: rtl/usb_bit_unstuff.sv
// usb_bit_unstuff: tracks consecutive ones and classifies each decoded bit as data, stuffed or stuff error
module usb_bit_unstuff
    import usb_rx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic valid_i,
    input  logic bit_i,
    output logic keep_o,
    output logic stuff_err_o
);
    logic [2:0] ones_q, ones_d;
    logic       slot;
    always_comb begin
        slot        = ones_q == 3'(STUFF_LIMIT);
        keep_o      = valid_i && !slot;
        stuff_err_o = valid_i && slot && bit_i;
        ones_d      = clr_i ? 3'd0 : !valid_i ? ones_q : (slot || !bit_i) ? 3'd0 : ones_q + 3'd1;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ones_q <= 3'd0;
        else     ones_q <= ones_d;
    end
endmodule

// File: rtl/usb_rx_ctrl.sv
// usb_rx_ctrl: SYNC hunt, bit unstuffing, LSB-first byte assembly and EOP/error framing for USB FS receive
module usb_rx_ctrl
    import usb_rx_pkg::*;
#(
    parameter int SYNC_MIN_ZEROS = 5,
    parameter int EOP_SE0_MIN    = 2,
    parameter int CNT_W          = 11
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_en,
    input  logic             phase_lock,
    input  logic             line_strobe,
    input  logic [1:0]       line_state,
    input  logic             dec_bit,
    input  logic             dec_valid,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             rx_active,
    output logic             rx_eop,
    output logic             rx_error,
    output logic [1:0]       rx_err_code,
    output logic [CNT_W-1:0] rx_byte_cnt
);
    rx_state_t        state_q, state_d;
    logic [7:0]       zeros_q, zeros_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [6:0]       shreg_q, shreg_d;
    logic [1:0]       se0_q, se0_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d, active_q, active_d, eop_q, eop_d, error_q, error_d;
    logic [1:0]       code_q, code_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clr, keep, stuff_err, abort;
    logic [1:0]       abort_code;
    logic             ls_j, ls_k, ls_se0, ls_se1;

    assign ls_j   = line_strobe && line_state == LS_J;
    assign ls_k   = line_strobe && line_state == LS_K;
    assign ls_se0 = line_strobe && line_state == LS_SE0;
    assign ls_se1 = line_strobe && line_state == LS_SE1;

    usb_bit_unstuff u_unstuff (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (clr),
        .valid_i     (dec_valid && state_q == ST_DATA),
        .bit_i       (dec_bit),
        .keep_o      (keep),
        .stuff_err_o (stuff_err)
    );

    always_comb begin
        state_d    = state_q;
        zeros_d    = zeros_q;
        bit_cnt_d  = bit_cnt_q;
        shreg_d    = shreg_q;
        se0_d      = se0_q;
        data_d     = data_q;
        valid_d    = 1'b0;
        active_d   = active_q;
        eop_d      = 1'b0;
        error_d    = 1'b0;
        code_d     = code_q;
        cnt_d      = cnt_q;
        clr        = 1'b0;
        abort      = 1'b0;
        abort_code = ERR_NONE;
        case (state_q)
            ST_IDLE: if (rx_en && phase_lock) begin
                state_d = ST_HUNT;
                zeros_d = 8'd0;
            end
            ST_HUNT: if (dec_valid) begin
                if (!dec_bit) zeros_d = zeros_q == 8'hFF ? zeros_q : zeros_q + 8'd1;
                else if (zeros_q >= 8'(SYNC_MIN_ZEROS)) begin
                    state_d   = ST_DATA;
                    active_d  = 1'b1;
                    bit_cnt_d = 3'd0;
                    cnt_d     = '0;
                    code_d    = ERR_NONE;
                    clr       = 1'b1;
                end else zeros_d = 8'd0;
            end
            ST_DATA: begin
                // the late bit of a same-cycle SE0 strobe is shifted in before EOP is entered
                if (keep) begin
                    shreg_d   = {dec_bit, shreg_q[6:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        valid_d = 1'b1;
                        data_d  = {dec_bit, shreg_q};
                        cnt_d   = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
                    end
                end
                if (stuff_err) begin
                    abort      = 1'b1;
                    abort_code = ERR_STUFF;
                end else if (ls_se1 || !phase_lock) begin
                    abort      = 1'b1;
                    abort_code = ERR_LINE;
                end else if (ls_se0) begin
                    state_d = ST_EOP;
                    se0_d   = 2'd1;
                end
            end
            ST_EOP: begin
                if (ls_se1 || !phase_lock) begin
                    abort      = 1'b1;
                    abort_code = ERR_LINE;
                end else if (ls_se0) se0_d = &se0_q ? se0_q : se0_q + 2'd1;
                else if (ls_j && se0_q >= 2'(EOP_SE0_MIN) && bit_cnt_q == 3'd0) begin
                    eop_d    = 1'b1;
                    active_d = 1'b0;
                    state_d  = ST_HUNT;
                    zeros_d  = 8'd0;
                end else if (ls_j || ls_k) begin
                    abort      = 1'b1;
                    abort_code = ERR_ALIGN;
                end
            end
            ST_WAIT_J: if (ls_j && phase_lock) begin
                state_d = ST_HUNT;
                zeros_d = 8'd0;
            end
            default: state_d = ST_IDLE;
        endcase
        if (!rx_en && active_q) begin
            abort      = 1'b1;
            abort_code = ERR_LINE;
        end
        if (abort) begin
            valid_d  = 1'b0;
            eop_d    = 1'b0;
            error_d  = 1'b1;
            code_d   = abort_code;
            active_d = 1'b0;
            state_d  = ST_WAIT_J;
        end
        if (!rx_en) begin
            state_d  = ST_IDLE;
            active_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            zeros_q   <= 8'd0;
            bit_cnt_q <= 3'd0;
            shreg_q   <= 7'd0;
            se0_q     <= 2'd0;
            data_q    <= 8'd0;
            valid_q   <= 1'b0;
            active_q  <= 1'b0;
            eop_q     <= 1'b0;
            error_q   <= 1'b0;
            code_q    <= ERR_NONE;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            zeros_q   <= zeros_d;
            bit_cnt_q <= bit_cnt_d;
            shreg_q   <= shreg_d;
            se0_q     <= se0_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            active_q  <= active_d;
            eop_q     <= eop_d;
            error_q   <= error_d;
            code_q    <= code_d;
            cnt_q     <= cnt_d;
        end
    end

    assign rx_data     = data_q;
    assign rx_valid    = valid_q;
    assign rx_active   = active_q;
    assign rx_eop      = eop_q;
    assign rx_error    = error_q;
    assign rx_err_code = code_q;
    assign rx_byte_cnt = cnt_q;
endmodule
